// File: rtl/disp_pkg.sv
// Shared definitions for the display history controller: display modes,
// datapath width and the layout of one history entry.
package disp_pkg;

  localparam logic MODE_DEC = 1'b0;
  localparam logic MODE_BIN = 1'b1;

  localparam int DISP_W        = 8;
  localparam int DEFAULT_DEPTH = 4;

  // One captured datapath result together with its overflow flag.
  typedef struct packed {
    logic              ovf;
    logic [DISP_W-1:0] value;
  } hist_entry_t;

endpackage

// File: rtl/disp_hist_ctrl_btn_rise.sv
// Turns a debounced, synchronised button level into a one-cycle press pulse.
// The previous level starts at 1 so a button already held when reset
// releases does not register as a press.
module btn_rise (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic pulse_o
);

  logic prevLevel_q;

  assign pulse_o = level_i & ~prevLevel_q;

  // Remember last cycle's level so only a 0->1 transition makes a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      prevLevel_q <= 1'b1;
    end else begin
      prevLevel_q <= level_i;
    end
  end

endmodule

// File: rtl/disp_hist_ctrl.sv
// Front end for the four-digit 7-segment decoder. Keeps a ring of recent
// datapath results, lets the user step back through them, toggles the
// decimal/binary display mode, and blinks the display when the shown entry
// overflowed.
module disp_hist_ctrl
  import disp_pkg::*;
#(
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int BLINK_DIV = 25000000,
  localparam int IW        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DISP_W-1:0] din,
  input  logic              din_valid,
  input  logic              din_ovf,
  input  logic              btn_mode,
  input  logic              btn_prev,
  input  logic              btn_clear,
  output logic [DISP_W-1:0] x,
  output logic              mode,
  output logic              enable,
  output logic [IW-1:0]     view_idx,
  output logic [IW:0]       count
);

  localparam int              BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [IW:0]     FULL_COUNT = (IW + 1)'(DEPTH);

  logic modePress;
  logic prevPress;
  logic clearPress;

  btn_rise uModeRise (
    .clk    (clk),
    .reset  (reset),
    .level_i(btn_mode),
    .pulse_o(modePress)
  );

  btn_rise uPrevRise (
    .clk    (clk),
    .reset  (reset),
    .level_i(btn_prev),
    .pulse_o(prevPress)
  );

  btn_rise uClearRise (
    .clk    (clk),
    .reset  (reset),
    .level_i(btn_clear),
    .pulse_o(clearPress)
  );

  hist_entry_t histMem [DEPTH];

  logic [DISP_W-1:0] x_q, x_d;
  logic              mode_q, mode_d;
  logic              enable_q, enable_d;
  logic [IW-1:0]     viewIdx_q, viewIdx_d;
  logic [IW:0]       count_q, count_d;
  logic [IW-1:0]     wptr_q, wptr_d;
  logic [BW-1:0]     blinkCnt_q, blinkCnt_d;
  logic              blinkPhase_q, blinkPhase_d;
  logic              shownOvf_q, shownOvf_d;

  logic [IW-1:0]     nextView;
  logic [IW-1:0]     rdIdx;
  hist_entry_t       rdEntry;

  // Stepping back wraps to the newest entry once the oldest valid one is shown;
  // the read index counts backwards from the slot most recently written.
  assign nextView = ({1'b0, viewIdx_q} == (count_q - 1'b1)) ? '0 : viewIdx_q + 1'b1;
  assign rdIdx    = wptr_q - 1'b1 - nextView;
  assign rdEntry  = histMem[rdIdx];

  assign x        = x_q;
  assign mode     = mode_q;
  assign enable   = enable_q;
  assign view_idx = viewIdx_q;
  assign count    = count_q;

  // Store each new result; clear wins over a same-cycle capture, so that
  // capture never reaches the ring.
  always_ff @(posedge clk) begin
    if (!reset && !clearPress && din_valid) begin
      histMem[wptr_q] <= '{ovf: din_ovf, value: din};
    end
  end

  // Next-state selection: clear beats capture beats stepping back, while the
  // mode toggle runs alongside everything. With nothing happening, an
  // overflowed entry advances the blink timer.
  always_comb begin
    x_d          = x_q;
    mode_d       = mode_q;
    enable_d     = enable_q;
    viewIdx_d    = viewIdx_q;
    count_d      = count_q;
    wptr_d       = wptr_q;
    blinkCnt_d   = blinkCnt_q;
    blinkPhase_d = blinkPhase_q;
    shownOvf_d   = shownOvf_q;

    if (modePress) begin
      mode_d = (mode_q == MODE_DEC) ? MODE_BIN : MODE_DEC;
    end

    if (clearPress) begin
      count_d      = '0;
      viewIdx_d    = '0;
      enable_d     = 1'b0;
      x_d          = '0;
      shownOvf_d   = 1'b0;
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b1;
    end else if (din_valid) begin
      wptr_d       = wptr_q + 1'b1;
      count_d      = (count_q == FULL_COUNT) ? count_q : count_q + 1'b1;
      viewIdx_d    = '0;
      x_d          = din;
      shownOvf_d   = din_ovf;
      enable_d     = 1'b1;
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b1;
    end else if (prevPress && (count_q != '0)) begin
      viewIdx_d    = nextView;
      x_d          = rdEntry.value;
      shownOvf_d   = rdEntry.ovf;
      enable_d     = 1'b1;
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b1;
    end else if ((count_q != '0) && shownOvf_q) begin
      if (blinkCnt_q == BLINK_LAST) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
        enable_d     = ~blinkPhase_q;
      end else begin
        blinkCnt_d   = blinkCnt_q + 1'b1;
        enable_d     = blinkPhase_q;
      end
    end
  end

  // Register every output and the ring bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q          <= '0;
      mode_q       <= MODE_DEC;
      enable_q     <= 1'b0;
      viewIdx_q    <= '0;
      count_q      <= '0;
      wptr_q       <= '0;
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b1;
      shownOvf_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      mode_q       <= mode_d;
      enable_q     <= enable_d;
      viewIdx_q    <= viewIdx_d;
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      blinkCnt_q   <= blinkCnt_d;
      blinkPhase_q <= blinkPhase_d;
      shownOvf_q   <= shownOvf_d;
    end
  end

endmodule

// File: tb/tb_disp_hist_ctrl.sv
// Testbench for disp_hist_ctrl: directed scenarios with literal expectations
// plus a randomized run, all checked against a queue-based model every cycle.
module tb_disp_hist_ctrl;

  localparam int DEPTH     = 4;
  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ovf;
  logic       btn_mode;
  logic       btn_prev;
  logic       btn_clear;
  logic [7:0] x;
  logic       mode;
  logic       enable;
  logic [1:0] view_idx;
  logic [2:0] count;

  disp_hist_ctrl #(
    .DEPTH    (DEPTH),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_valid(din_valid),
    .din_ovf  (din_ovf),
    .btn_mode (btn_mode),
    .btn_prev (btn_prev),
    .btn_clear(btn_clear),
    .x        (x),
    .mode     (mode),
    .enable   (enable),
    .view_idx (view_idx),
    .count    (count)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  // Model state: history newest-first, shown position, and cycles since the
  // shown entry was loaded (drives the blink pattern).
  logic [8:0] hist [$];
  int  mView, mX, mMode, mEn, mAge;
  bit  mShownOvf, mPrevM, mPrevP, mPrevC, modelValid;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep();
    bit pM, pP, pC;
    if (reset) begin
      hist.delete();
      mView = 0; mX = 0; mMode = 0; mEn = 0; mAge = 0; mShownOvf = 0;
      mPrevM = 1; mPrevP = 1; mPrevC = 1;
      modelValid = 1;
    end else begin
      pM = btn_mode  && !mPrevM;
      pP = btn_prev  && !mPrevP;
      pC = btn_clear && !mPrevC;
      mPrevM = btn_mode; mPrevP = btn_prev; mPrevC = btn_clear;
      if (pM) mMode = 1 - mMode;
      if (pC) begin
        hist.delete();
        mView = 0; mX = 0; mEn = 0; mShownOvf = 0; mAge = 0;
      end else if (din_valid) begin
        hist.push_front({din_ovf, din});
        if (hist.size() > DEPTH) hist.delete(DEPTH);
        mView = 0; mX = int'(din); mShownOvf = din_ovf; mAge = 0; mEn = 1;
      end else if (pP && hist.size() > 0) begin
        mView = (mView + 1) % hist.size();
        mX = int'(hist[mView][7:0]);
        mShownOvf = hist[mView][8];
        mAge = 0; mEn = 1;
      end else if (hist.size() > 0) begin
        mAge++;
        if (mShownOvf) mEn = (((mAge / BLINK_DIV) % 2) == 0) ? 1 : 0;
        else           mEn = 1;
      end
    end
  endtask

  // Advance the model on each edge, then compare every output just after it.
  always @(posedge clk) begin
    modelStep();
    #1;
    if (modelValid) begin
      checkOutput("model_x",     int'(x),        mX);
      checkOutput("model_mode",  int'(mode),     mMode);
      checkOutput("model_en",    int'(enable),   mEn);
      checkOutput("model_view",  int'(view_idx), mView);
      checkOutput("model_count", int'(count),    hist.size());
    end
  end

  task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d, input bit o,
                               input bit bm, input bit bp, input bit bc);
    reset = r; din_valid = v; din = d; din_ovf = o;
    btn_mode = bm; btn_prev = bp; btn_clear = bc;
    @(negedge clk);
  endtask

  int expX [4]   = '{8, 7, 6, 9};
  int expV [4]   = '{1, 2, 3, 0};
  int blinkPat [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
  bit rbm, rbp, rbc;

  initial begin
    reset = 1; din = 0; din_valid = 0; din_ovf = 0;
    btn_mode = 0; btn_prev = 0; btn_clear = 0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_x", int'(x), 0);
    checkOutput("rst_en", int'(enable), 0);
    checkOutput("rst_count", int'(count), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // First capture of -10
    applyStimulus(0, 1, 8'hF6, 0, 0, 0, 0);
    checkOutput("first_x", int'(x), 246);
    checkOutput("first_en", int'(enable), 1);
    checkOutput("first_count", int'(count), 1);
    checkOutput("first_view", int'(view_idx), 0);
    checkOutput("first_mode", int'(mode), 0);

    // Overfill and step back through history
    for (int i = 5; i <= 9; i++) applyStimulus(0, 1, 8'(i), 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      checkOutput("prev_x", int'(x), expX[i]);
      checkOutput("prev_view", int'(view_idx), expV[i]);
      checkOutput("prev_count", int'(count), 4);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end

    // Blink on overflowed entry, then steady on a clean one
    applyStimulus(0, 1, 8'h80, 1, 0, 0, 0);
    checkOutput("blink_x", int'(x), 128);
    checkOutput("blink_en0", int'(enable), blinkPat[0]);
    for (int i = 1; i < 9; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("blink_en", int'(enable), blinkPat[i]);
    end
    applyStimulus(0, 1, 8'd3, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("steady_en", int'(enable), 1);
    end

    // Clear drops a same-cycle capture
    applyStimulus(0, 1, 8'd42, 0, 0, 0, 1);
    checkOutput("clr_count", int'(count), 0);
    checkOutput("clr_en", int'(enable), 0);
    checkOutput("clr_x", int'(x), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 8'd42, 0, 0, 0, 0);
    checkOutput("after_clr_count", int'(count), 1);
    checkOutput("after_clr_x", int'(x), 42);

    // Held mode button toggles once
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("mode_held", int'(mode), 1);
      checkOutput("mode_held_x", int'(x), 42);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("mode_second", int'(mode), 0);
    checkOutput("mode_second_x", int'(x), 42);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Buttons held through reset release do not fire
    applyStimulus(1, 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("held_rst_mode", int'(mode), 0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 8'(i), 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("held_rst_view", int'(view_idx), 0);
    checkOutput("held_rst_x", int'(x), 3);
    checkOutput("held_rst_mode2", int'(mode), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset while looking at an older entry
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkOutput("pre_rst_view", int'(view_idx), 2);
    checkOutput("pre_rst_x", int'(x), 1);
    checkOutput("pre_rst_mode", int'(mode), 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("mid_rst_x", int'(x), 0);
    checkOutput("mid_rst_mode", int'(mode), 0);
    checkOutput("mid_rst_en", int'(enable), 0);
    checkOutput("mid_rst_view", int'(view_idx), 0);
    checkOutput("mid_rst_count", int'(count), 0);

    // Randomized traffic against the model
    rbm = 0; rbp = 0; rbc = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)  rbm = ~rbm;
      if ($urandom_range(0, 2) == 0)  rbp = ~rbp;
      if ($urandom_range(0, 15) == 0) rbc = ~rbc;
      applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 3) == 0,
                    8'($urandom), $urandom_range(0, 2) == 0, rbm, rbp, rbc);
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/disp_hist_ctrl.md
Name: disp_hist_ctrl

Overview:
- Sequential front end that drives the four-digit 7-segment display decoder's x, mode and enable inputs.
- Captures 8-bit signed results from the datapath with a valid strobe, into a DEPTH-entry history ring.
- Lets the user step back through history, toggle between binary and decimal display, and clear history.
- Blinks the display when the shown entry carries an overflow flag.

Parameters:
- DEPTH, 4, number of history entries (power of 2, 2..16)
- BLINK_DIV, 25000000, clk cycles per blink half-period (override small in simulation)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- din  input  8  signed result from datapath (2's complement)
- din_valid  input  1  single-cycle strobe; din/din_ovf captured on rising clk when high
- din_ovf  input  1  overflow flag accompanying din
- btn_mode  input  1  level, active-high, already synchronised and debounced
- btn_prev  input  1  level, active-high, already synchronised and debounced
- btn_clear  input  1  level, active-high, already synchronised and debounced
- x  output  8  signed value to display decoder
- mode  output  1  0 = decimal, 1 = binary (feeds decoder mode)
- enable  output  1  display enable (feeds decoder enable)
- view_idx  output  log2(DEPTH)  age of shown entry, 0 = newest
- count  output  log2(DEPTH)+1  number of valid entries

Behaviour:
- All outputs registered. An event sampled at edge k is reflected on outputs immediately after edge k.
- Reset values: x=0, mode=0, enable=0, view_idx=0, count=0, write pointer=0, blink counter=0, blink phase=1. Buffer contents are don't-care.
- Reset mid-operation discards all history and returns to the reset state at the next edge.
- Button press = rising edge of the level input:
  - Each button has a registered previous level, reset to 1 so a button held through reset does not fire.
  - A held button produces exactly one press.
- Priority per edge: reset > clear > din_valid > btn_prev. btn_mode is independent of all of these.
- Clear press:
  - count=0, view_idx=0, enable=0, x=0.
  - A din_valid in the same cycle is dropped.
- din_valid:
  - Write {din_ovf,din} at the write pointer; pointer += 1 mod DEPTH.
  - count saturates at DEPTH. When full, the oldest entry is overwritten.
  - view_idx forced to 0, x=din, enable=1, blink counter=0, blink phase=1.
  - A btn_prev press in the same cycle is ignored.
- btn_prev press:
  - count=0: no effect.
  - Otherwise view_idx += 1, wrapping to 0 when view_idx == count-1.
  - x = entry at (wptr-1-view_idx) mod DEPTH.
  - Blink counter=0, blink phase=1.
  - count=1: view_idx stays 0 and x is reloaded unchanged.
- btn_mode press: mode toggles. No effect on x, enable or history. Can coincide with any other event.
- Enable / blink:
  - count=0: enable=0.
  - Shown entry ovf=0: enable=1.
  - Shown entry ovf=1: the blink counter counts 0..BLINK_DIV-1. On wrap, blink phase toggles; enable = blink phase.
  - The blink counter is held at 0 while the shown entry ovf=0.
- Width rules:
  - x carries stored bits unchanged; no sign manipulation here.
  - view_idx and pointer arithmetic are modulo DEPTH.
  - count compare is unsigned.

Decomposition:
- Shared package (disp_pkg):
  - MODE_DEC=1'b0, MODE_BIN=1'b1
  - DISP_W=8
  - Typedef for a history entry as a packed struct {ovf, value[7:0]}
  - Default DEPTH
- Sub-module btn_rise:
  - Ports: clk, reset, level in, pulse out. Previous-level register resets to 1.
  - Instantiated three times.
- History ring, view logic and blink counter stay in the top module.

Test Plan:
- Reset, then din_valid with din=8'hF6 (-10), ovf=0 -> next cycle x=8'hF6, enable=1, count=1, view_idx=0, mode=0.
- Push 5, 6, 7, 8, 9 (DEPTH=4); press btn_prev four times -> x sequence 8, 7, 6, then 9 (wrap); count stays 4; view_idx goes 1, 2, 3, 0.
- BLINK_DIV=4; push din=8'h80 with ovf=1 -> enable pattern 1,1,1,1,0,0,0,0,1... Push 3 with ovf=0 -> enable=1 steady, blink counter 0.
- btn_clear and din_valid (din=42) in the same cycle -> count=0, enable=0, x=0. Next push of 42 -> count=1, x=42.
- Hold btn_mode high for 10 cycles, release, press again -> mode 0→1 once, then 1→0; x unchanged throughout.
- Hold btn_prev high across reset deassertion -> no step after reset. Assert reset while showing view_idx=2 -> all outputs at reset values next cycle.
